// File: rtl/bldcm_ramp_sequencer.sv
// rtl/bldcm_ramp_sequencer.sv - soft-start / soft-stop Avalon-MM write master for the mBldcm slave
// Programs PWM setup, enables the bridge, sets frequency, then ramps PWM compare in timed steps.
module bldcm_ramp_sequencer #(
   parameter logic [31:0] pStepCycles = 32'd50000,
   parameter logic [16:0] pCompareMax = 17'h10000
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iStart,
   input  logic        iStop,
   input  logic [31:0] iTargetFreq,
   input  logic [16:0] iTargetCompare,
   input  logic [15:0] iStep,
   input  logic [15:0] iPwmPeriod,
   input  logic [5:0]  iPwmPrescale,
   output logic [1:0]  oAddr,
   output logic        oWrite,
   output logic [31:0] oWdata,
   input  logic        iWaitrequest,
   output logic        oBusy,
   output logic        oRunning,
   output logic        oDone,
   output logic [16:0] oCompare
);

   typedef enum logic [3:0] {
      IDLE, WR_CMP0, WR_CTRL, WR_FREQ, RAMP_WAIT, RAMP_WR, RUN, DOWN_WAIT, DOWN_WR, WR_DIS
   } state_t;

   localparam logic [31:0] RELOAD = pStepCycles - 32'd1;

   state_t      state;
   logic [31:0] freq_q;
   logic [16:0] step_q;
   logic [15:0] period_q;
   logic [5:0]  prescale_q;
   logic [16:0] cur;
   logic [31:0] count;
   logic        stop_pend;

   logic [16:0] target;
   logic [17:0] sum;
   logic [16:0] up_next;
   logic [16:0] down_next;
   logic [31:0] ctrl_base;
   logic        stop_seen;

   always_comb begin
      target    = (iTargetCompare > pCompareMax) ? pCompareMax : iTargetCompare;
      sum       = {1'b0, cur} + {1'b0, step_q};
      // Moving toward the target always saturates at it, so a lowered target is reached in one step.
      up_next   = (sum > {1'b0, target}) ? target : sum[16:0];
      down_next = (cur > step_q) ? (cur - step_q) : 17'd0;
      ctrl_base = {4'h0, period_q, prescale_q, 1'b0, 3'h0, 1'b0, 1'b0};
      stop_seen = iStop | stop_pend;
   end

   assign oBusy    = (state != IDLE);
   assign oRunning = (state == RUN);

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state      <= IDLE;
         oWrite     <= 1'b0;
         oAddr      <= 2'd0;
         oWdata     <= 32'd0;
         oCompare   <= 17'd0;
         oDone      <= 1'b0;
         freq_q     <= 32'd0;
         step_q     <= 17'd0;
         period_q   <= 16'd0;
         prescale_q <= 6'd0;
         cur        <= 17'd0;
         count      <= 32'd0;
         stop_pend  <= 1'b0;
      end else begin
         oDone <= 1'b0;
         case (state)
            IDLE: begin
               if (iStart && !iStop) begin
                  freq_q     <= iTargetFreq;
                  step_q     <= (iStep == 16'd0) ? 17'd1 : {1'b0, iStep};
                  period_q   <= iPwmPeriod;
                  prescale_q <= iPwmPrescale;
                  cur        <= 17'd0;
                  stop_pend  <= 1'b0;
                  state      <= WR_CMP0;
               end
            end
            // Each write state spends its first cycle idle on the bus, then strobes until accepted.
            WR_CMP0: begin
               if (iStop) stop_pend <= 1'b1;
               if (!oWrite) begin
                  oWrite <= 1'b1;
                  oAddr  <= 2'd1;
                  oWdata <= 32'd0;
               end else if (!iWaitrequest) begin
                  oWrite    <= 1'b0;
                  oCompare  <= 17'd0;
                  count     <= RELOAD;
                  stop_pend <= 1'b0;
                  state     <= stop_seen ? DOWN_WAIT : WR_CTRL;
               end
            end
            WR_CTRL: begin
               if (iStop) stop_pend <= 1'b1;
               if (!oWrite) begin
                  oWrite <= 1'b1;
                  oAddr  <= 2'd2;
                  oWdata <= ctrl_base | 32'd1;
               end else if (!iWaitrequest) begin
                  oWrite    <= 1'b0;
                  count     <= RELOAD;
                  stop_pend <= 1'b0;
                  state     <= stop_seen ? DOWN_WAIT : WR_FREQ;
               end
            end
            WR_FREQ: begin
               if (iStop) stop_pend <= 1'b1;
               if (!oWrite) begin
                  oWrite <= 1'b1;
                  oAddr  <= 2'd0;
                  oWdata <= freq_q;
               end else if (!iWaitrequest) begin
                  oWrite    <= 1'b0;
                  count     <= RELOAD;
                  stop_pend <= 1'b0;
                  state     <= stop_seen ? DOWN_WAIT : RAMP_WAIT;
               end
            end
            RAMP_WAIT: begin
               if (iStop) begin
                  count <= RELOAD;
                  state <= DOWN_WAIT;
               end else if (count == 32'd0) begin
                  cur   <= up_next;
                  state <= RAMP_WR;
               end else begin
                  count <= count - 32'd1;
               end
            end
            RAMP_WR: begin
               if (iStop) stop_pend <= 1'b1;
               if (!oWrite) begin
                  oWrite <= 1'b1;
                  oAddr  <= 2'd1;
                  oWdata <= {15'd0, cur};
               end else if (!iWaitrequest) begin
                  oWrite    <= 1'b0;
                  oCompare  <= cur;
                  count     <= RELOAD;
                  stop_pend <= 1'b0;
                  if (stop_seen)          state <= DOWN_WAIT;
                  else if (cur == target) state <= RUN;
                  else                    state <= RAMP_WAIT;
               end
            end
            RUN: begin
               if (iStop) begin
                  count <= RELOAD;
                  state <= DOWN_WAIT;
               end else if (target != cur) begin
                  count <= RELOAD;
                  state <= RAMP_WAIT;
               end
            end
            DOWN_WAIT: begin
               if (count == 32'd0) begin
                  cur   <= down_next;
                  state <= DOWN_WR;
               end else begin
                  count <= count - 32'd1;
               end
            end
            DOWN_WR: begin
               if (!oWrite) begin
                  oWrite <= 1'b1;
                  oAddr  <= 2'd1;
                  oWdata <= {15'd0, cur};
               end else if (!iWaitrequest) begin
                  oWrite   <= 1'b0;
                  oCompare <= cur;
                  count    <= RELOAD;
                  state    <= (cur == 17'd0) ? WR_DIS : DOWN_WAIT;
               end
            end
            WR_DIS: begin
               if (!oWrite) begin
                  oWrite <= 1'b1;
                  oAddr  <= 2'd2;
                  oWdata <= ctrl_base;
               end else if (!iWaitrequest) begin
                  oWrite <= 1'b0;
                  oDone  <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bldcm_ramp_sequencer.sv
// tb/tb_bldcm_ramp_sequencer.sv - self-checking bench for bldcm_ramp_sequencer
// A negedge bus monitor logs accepted writes; a behavioural model predicts the write stream.
module tb_bldcm_ramp_sequencer;

   localparam int STEP_CYC = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop;
   logic [31:0] tfreq;
   logic [16:0] tcmp;
   logic [15:0] step, period;
   logic [5:0]  prescale;
   logic [1:0]  addr;
   logic        wr;
   logic [31:0] wdata;
   logic        waitreq;
   logic        busy, running, done;
   logic [16:0] compare;

   always #5 clk = ~clk;

   bldcm_ramp_sequencer #(.pStepCycles(STEP_CYC), .pCompareMax(17'h10000)) dut (
      .iClock(clk), .iReset(rst), .iStart(start), .iStop(stop),
      .iTargetFreq(tfreq), .iTargetCompare(tcmp), .iStep(step),
      .iPwmPeriod(period), .iPwmPrescale(prescale),
      .oAddr(addr), .oWrite(wr), .oWdata(wdata), .iWaitrequest(waitreq),
      .oBusy(busy), .oRunning(running), .oDone(done), .oCompare(compare)
   );

   int n_vec = 0;
   int n_err = 0;

   // Bus monitor
   logic [33:0] wr_q[$];
   int          wr_cyc[$];
   int          wr_len[$];
   int          cyc = 0, cur_len = 0, done_cnt = 0, proto_err = 0;
   logic [1:0]  p_addr = 2'd0;
   logic [31:0] p_data = 32'd0;
   bit          p_stall = 1'b0, just_done = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (wr === 1'b1) begin
         if (p_stall && (addr !== p_addr || wdata !== p_data)) proto_err++;
         if (just_done) proto_err++;
         cur_len++;
         if (waitreq === 1'b0) begin
            wr_q.push_back({addr, wdata});
            wr_cyc.push_back(cyc);
            wr_len.push_back(cur_len);
            cur_len = 0;
         end
      end
      just_done = (wr === 1'b1) && (waitreq === 1'b0);
      p_stall   = (wr === 1'b1) && (waitreq === 1'b1);
      p_addr    = addr;
      p_data    = wdata;
   end

   // Behavioural model of the write stream
   logic [33:0] exp_q[$];
   int          m_cur, m_step;
   logic [31:0] m_ctrl;

   task automatic push_exp(input logic [1:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic model_start(input int f, input int per, input int pre, input int st);
      m_step = (st == 0) ? 1 : st;
      m_ctrl = 32'((per << 12) | (pre << 6));
      m_cur  = 0;
      push_exp(2'd1, 32'd0);
      push_exp(2'd2, m_ctrl | 32'd1);
      push_exp(2'd0, 32'(f));
   endtask

   task automatic model_ramp(input int target);
      int t;
      t = (target > 65536) ? 65536 : target;
      do begin
         m_cur = (m_cur + m_step > t) ? t : m_cur + m_step;
         push_exp(2'd1, 32'(m_cur));
      end while (m_cur != t);
   endtask

   task automatic model_down();
      do begin
         m_cur = (m_cur > m_step) ? m_cur - m_step : 0;
         push_exp(2'd1, 32'(m_cur));
      end while (m_cur != 0);
      push_exp(2'd2, m_ctrl);
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cmp_writes(input string tag);
      check({tag, " count"}, 64'(wr_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s wr%0d", tag, i),
               (i < wr_q.size()) ? {30'd0, wr_q[i]} : 64'hDEAD_BEEF_DEAD_BEEF,
               {30'd0, exp_q[i]});
      wr_q.delete(); wr_cyc.delete(); wr_len.delete(); exp_q.delete();
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   // which: 0 running high, 1 running low, 2 idle, 3 >=arg writes logged, 4 write to addr arg on bus
   task automatic wait_for(input int which, input int arg, input string tag);
      bit ok = 1'b0;
      for (int n = 0; n < 4000 && !ok; n++) begin
         tick();
         case (which)
            0:       ok = (running === 1'b1);
            1:       ok = (running === 1'b0);
            2:       ok = (busy === 1'b0);
            3:       ok = (wr_q.size() >= arg);
            default: ok = (wr === 1'b1) && (addr === 2'(arg));
         endcase
      end
      check({tag, " reached"}, 64'(ok), 64'd1);
   endtask

   task automatic start_seq(input int f, input int per, input int pre, input int st);
      tfreq = 32'(f); period = 16'(per); prescale = 6'(pre); step = 16'(st);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic stop_seq(input string tag);
      int d0;
      d0 = done_cnt;
      stop = 1'b1;
      wait_for(2, 0, {tag, " idle"});
      stop = 1'b0;
      repeat (3) tick();
      model_down();
      cmp_writes(tag);
      check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " compare"}, 64'(compare), 64'd0);
   endtask

   initial begin
      int f, per, pre, st, tg;
      rst = 1'b1; start = 1'b0; stop = 1'b0; waitreq = 1'b0;
      tfreq = '0; tcmp = '0; step = '0; period = '0; prescale = '0;
      repeat (3) tick();
      check("rst write", 64'(wr), 64'd0);
      check("rst addr", 64'(addr), 64'd0);
      check("rst wdata", 64'(wdata), 64'd0);
      check("rst compare", 64'(compare), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst running", 64'(running), 64'd0);
      check("rst done", 64'(done), 64'd0);
      rst = 1'b0;
      tick();

      // Directed soft start with a 5-cycle stall on the control write
      tcmp = 17'd12;
      start_seq(3472, 16'h000F, 3, 4);
      wait_for(4, 2, "ctrl write");
      waitreq = 1'b1;
      repeat (5) tick();
      waitreq = 1'b0;
      wait_for(0, 0, "run A");
      model_start(3472, 16'h000F, 3, 4);
      model_ramp(12);
      check("ctrl stall len", (wr_len.size() > 1) ? 64'(wr_len[1]) : 64'd0, 64'd6);
      check("ctrl word", (wr_q.size() > 1) ? {30'd0, wr_q[1]} : 64'd0, {30'd0, 2'd2, 32'h0000_F0C1});
      for (int i = 4; i < 6; i++)
         check($sformatf("spacing %0d", i),
               (wr_cyc.size() > i) ? 64'(wr_cyc[i] - wr_cyc[i-1] >= 11) : 64'd0, 64'd1);
      cmp_writes("run A");
      check("run A compare", 64'(compare), 64'd12);

      tcmp = 17'd3;
      wait_for(1, 0, "retarget 3 leave");
      wait_for(0, 0, "retarget 3 run");
      model_ramp(3);
      cmp_writes("retarget 3");
      check("retarget 3 compare", 64'(compare), 64'd3);

      tcmp = 17'd12;
      wait_for(1, 0, "retarget 12 leave");
      wait_for(0, 0, "retarget 12 run");
      model_ramp(12);
      cmp_writes("retarget 12");
      stop_seq("stop A");

      // Ceiling saturation
      tcmp = 17'h1FFFF;
      f = int'($urandom); per = int'($urandom_range(0, 16'hFFFF)); pre = int'($urandom_range(0, 63));
      start_seq(f, per, pre, 16'hFFFF);
      wait_for(0, 0, "sat run");
      model_start(f, per, pre, 16'hFFFF);
      model_ramp(17'h1FFFF);
      cmp_writes("sat");
      check("sat compare", 64'(compare), 64'h10000);
      stop_seq("sat stop");

      // Step of zero behaves as one
      tcmp = 17'd3;
      start_seq(77, 5, 1, 0);
      wait_for(0, 0, "step0 run");
      model_start(77, 5, 1, 0);
      model_ramp(3);
      cmp_writes("step0");
      stop_seq("step0 stop");

      // Randomised runs with a random retarget
      for (int r = 0; r < 4; r++) begin
         f = int'($urandom); per = int'($urandom_range(0, 16'hFFFF)); pre = int'($urandom_range(0, 63));
         st = int'($urandom_range(0, 20)); tg = int'($urandom_range(0, 60));
         tcmp = 17'(tg);
         start_seq(f, per, pre, st);
         wait_for(0, 0, $sformatf("rnd%0d run", r));
         model_start(f, per, pre, st);
         model_ramp(tg);
         cmp_writes($sformatf("rnd%0d up", r));
         tg = int'($urandom_range(0, 60));
         if (tg != m_cur) begin
            tcmp = 17'(tg);
            wait_for(1, 0, $sformatf("rnd%0d leave", r));
            wait_for(0, 0, $sformatf("rnd%0d rerun", r));
            model_ramp(tg);
            cmp_writes($sformatf("rnd%0d retarget", r));
         end
         stop_seq($sformatf("rnd%0d stop", r));
      end

      // Reset in the middle of a ramp
      tcmp = 17'd40;
      start_seq(9, 2, 2, 2);
      wait_for(3, 5, "mid ramp");
      rst = 1'b1;
      tick();
      check("mid rst write", 64'(wr), 64'd0);
      check("mid rst busy", 64'(busy), 64'd0);
      check("mid rst compare", 64'(compare), 64'd0);
      rst = 1'b0;
      repeat (2) tick();
      check("post rst idle write", 64'(wr), 64'd0);
      wr_q.delete(); wr_cyc.delete(); wr_len.delete(); exp_q.delete();

      // Stop while the frequency write is on the bus
      tcmp = 17'd20;
      start_seq(555, 8, 4, 5);
      wait_for(4, 0, "freq write");
      model_start(555, 8, 4, 5);
      stop_seq("stop in freq");

      // Stop has priority over start in idle
      stop = 1'b1; start = 1'b1;
      repeat (5) tick();
      check("stop beats start", 64'(busy), 64'd0);
      stop = 1'b0; start = 1'b0;
      tick();

      check("bus protocol errors", 64'(proto_err), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bldcm_ramp_sequencer.md
Name: bldcm_ramp_sequencer

Overview:
Avalon-MM write-only master that drives the mBldcm register slave: freq (0), PWM compare (1), control (2). It runs a soft-start: programs the PWM setup, enables the bridge, writes the commutation frequency, then ramps PWM compare toward a target in fixed steps. On stop it ramps compare down to 0 and clears enable. It sits between the CPU-side motor command logic and mBldcm. It does not issue reads.

Parameters:
pStepCycles, 32'd50000, clock cycles between successive compare updates (min 1)
pCompareMax, 17'h10000, compare saturation ceiling (full duty)

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous, active-high reset
iStart  in  1  level; start sequence when idle
iStop  in  1  level; request ramp-down and disable
iTargetFreq  in  32  freq register value; latched on start
iTargetCompare  in  17  desired PWM compare; sampled live, clamped to pCompareMax
iStep  in  16  compare increment per step; 0 treated as 1; latched on start
iPwmPeriod  in  16  control[27:12]; latched on start
iPwmPrescale  in  6  control[11:6]; latched on start
oAddr  out  2  Avalon word address
oWrite  out  1  Avalon write strobe
oWdata  out  32  Avalon write data
iWaitrequest  in  1  slave stall; tie 0 for mBldcm
oBusy  out  1  high in every state except IDLE
oRunning  out  1  high only in RUN
oDone  out  1  one-cycle pulse when WR_DIS completes
oCompare  out  17  compare value most recently written

Behaviour:
- Reset (sync, sampled on iClock edge): state=IDLE, oWrite=0, oAddr=0, oWdata=0, oCompare=0, oBusy=0, oRunning=0, oDone=0, step counter=0.
- Bus rule: a write holds oWrite=1 with oAddr/oWdata stable until an edge with iWaitrequest=0. That edge completes the write. The FSM leaves the write state on the same edge. There are no back-to-back writes; at least one idle cycle follows each write.
- Control word: {4'h0, period[15:0], prescale[5:0], 1'b0 (W_PHASE), 3'h0, 1'b0, en}.
- States:
  IDLE: iStart=1 and iStop=0 -> latch inputs, cur=0, go to WR_CMP0.
  WR_CMP0: write addr1 = 0 -> WR_CTRL.
  WR_CTRL: write addr2 with en=1 -> WR_FREQ.
  WR_FREQ: write addr0 = latched freq -> RAMP_WAIT, counter=pStepCycles-1.
  RAMP_WAIT: count down. At 0, cur moves toward T=min(iTargetCompare,pCompareMax) by step, saturating at T (up or down). Go to RAMP_WR.
  RAMP_WR: write addr1=cur. If cur==T then RUN, else RAMP_WAIT with counter reloaded.
  RUN: if T != cur -> RAMP_WAIT.
  DOWN_WAIT: same counting. cur=max(cur-step,0) -> DOWN_WR.
  DOWN_WR: write addr1=cur. If cur==0 then WR_DIS, else DOWN_WAIT.
  WR_DIS: write addr2 with en=0 -> IDLE; oDone=1 on the following cycle.
- Stop: iStop=1 in RAMP_WAIT/RUN -> DOWN_WAIT next edge, counter reloaded.
  - In a write state, the current write completes first. Then the FSM goes to DOWN_WAIT instead of its normal successor.
  - During WR_CMP0/WR_CTRL/WR_FREQ it goes to DOWN_WAIT after the write; if cur==0 there, the first DOWN_WAIT expiry leads to WR_DIS via DOWN_WR writing 0.
  - iStop has priority over iStart. iStart is ignored while oBusy.
- oCompare updates on completion of each addr1 write.
- Arithmetic: 17-bit cur with an 18-bit intermediate for the add. No wrap at pCompareMax or 0.
- Changing the target mid-ramp is legal; the direction is re-evaluated at each step.

Test Plan:
- Reset then iStart with freq=3472, period=0x000F, prescale=3, step=4, target=12, pStepCycles=10, waitrequest=0. Required writes, in order:
  - addr1=0
  - addr2=0x0000F0C1
  - addr0=3472
  - then addr1=4, 8, 12, each 11+ cycles apart
  - then oRunning=1.
- In RUN, change target to 3 -> one write addr1=3 (saturate down, not 8), then RUN; oCompare=3.
- iStop in RUN with cur=12, step=4 -> writes addr1=8, 4, 0, then addr2=0x0000F0C0, then a single oDone pulse, then IDLE, oBusy=0.
- iWaitrequest held high 5 cycles during the WR_CTRL write -> oWrite, oAddr=2 and oWdata stay stable 6 cycles; no duplicate write.
- target=0x1FFFF, step=0xFFFF -> writes 0xFFFF, 0x10000, then RUN. Step=0 -> cur increments by 1.
- iReset asserted mid-ramp and iStop asserted during WR_FREQ:
  - Reset -> oWrite=0, state IDLE next edge.
  - Stop during WR_FREQ -> freq write completes, then the down path writes addr1=0 and the disable.
